countdown_timer_16bit: RTL and testbench

Loadable 16-bit down-counting timer: the decrementing counterpart of the free-running up counter already used in the design. Software or a controlling FSM loads a start value and issues `start`. The block counts down to zero at a prescaled rate, holds `busy` while running, and emits a one-cycle `done` pulse at terminal count. It sits beside the up counter and provides timeouts and fixed delays for neighbouring blocks.

---
 rtl/counter_pkg.sv | 11 +
 rtl/countdown_timer_16bit_tick_prescaler.sv | 30 +++
 rtl/countdown_timer_16bit.sv | 106 ++++++++++
 tb/tb_countdown_timer_16bit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter family (up counter and countdown timer).
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/countdown_timer_16bit_tick_prescaler.sv
// Divides clk by PRESCALE while enabled; tick is high on the last cycle of each period.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_async,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  // With PRESCALE = 1 the counter is pinned at 0, so tick reduces to enable.
  assign w_last = (r_cnt == LAST);
  assign tick   = enable && w_last;

  always_ff @(posedge clk) begin
    if (rst_async || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer_16bit.sv
// Loadable down-counting timer with prescaler, busy level and one-cycle done pulse.
// Optional auto-reload is built when COUNTDOWN_AUTORELOAD_EN is defined.
module countdown_timer_16bit
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_async,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
`ifdef COUNTDOWN_AUTORELOAD_EN
  input  logic             reload_mode,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  timer_state_t     r_state;
  timer_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_tick;
  logic             w_reload;
  logic             w_load_zero;

  assign w_load_zero = (load_val == '0);

`ifdef COUNTDOWN_AUTORELOAD_EN
  assign w_reload = reload_mode && !w_load_zero;
`else
  assign w_reload = 1'b0;
`endif

  // Prescaler is held cleared outside RUN, so every accepted start begins a full period.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk       (clk),
    .rst_async (rst_async),
    .clear     ((r_state != RUN) || stop),
    .enable    (r_state == RUN),
    .tick      (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !stop) begin
          if (w_load_zero) begin
            w_count_nxt = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_count_nxt = load_val;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          if (r_count > WIDTH'(1)) begin
            w_count_nxt = r_count - WIDTH'(1);
          end else if (w_reload) begin
            w_count_nxt = load_val;
            w_done_nxt  = 1'b1;
          end else begin
            w_count_nxt = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_async) begin
      r_state <= IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_countdown_timer_16bit.sv
// Directed bench: PRESCALE=1 and PRESCALE=4 instances; reload tests when COUNTDOWN_AUTORELOAD_EN is defined.
module tb_countdown_timer_16bit;

  logic        clk = 1'b0;
  logic        rst1, start1, stop1;
  logic [15:0] load1;
  logic [15:0] count1;
  logic        busy1, done1;
  logic        rst2, start2, stop2;
  logic [15:0] load2;
  logic [15:0] count2;
  logic        busy2, done2;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic        rmode1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  countdown_timer_16bit #(.WIDTH(16), .PRESCALE(1)) dut1 (
    .clk       (clk),
    .rst_async (rst1),
    .load_val  (load1),
    .start     (start1),
    .stop      (stop1),
`ifdef COUNTDOWN_AUTORELOAD_EN
    .reload_mode (rmode1),
`endif
    .count     (count1),
    .busy      (busy1),
    .done      (done1)
  );

  countdown_timer_16bit #(.WIDTH(16), .PRESCALE(4)) dut2 (
    .clk       (clk),
    .rst_async (rst2),
    .load_val  (load2),
    .start     (start2),
    .stop      (stop2),
`ifdef COUNTDOWN_AUTORELOAD_EN
    .reload_mode (1'b0),
`endif
    .count     (count2),
    .busy      (busy2),
    .done      (done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic [15:0] c, input logic b, input logic d);
    check({tag, ".count"}, 32'(count1), 32'(c));
    check({tag, ".busy"},  32'(busy1),  32'(b));
    check({tag, ".done"},  32'(done1),  32'(d));
  endtask

  task automatic check2(input string tag, input logic [15:0] c, input logic b, input logic d);
    check({tag, ".count"}, 32'(count2), 32'(c));
    check({tag, ".busy"},  32'(busy2),  32'(b));
    check({tag, ".done"},  32'(done2),  32'(d));
  endtask

  initial begin
    int  bc;
    int  got;
    rst1 = 1'b1; start1 = 1'b0; stop1 = 1'b0; load1 = '0;
    rst2 = 1'b1; start2 = 1'b0; stop2 = 1'b0; load2 = '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    rmode1 = 1'b0;
`endif
    step(); step();
    check1("reset", 16'd0, 1'b0, 1'b0);
    check2("reset2", 16'd0, 1'b0, 1'b0);
    rst1 = 1'b0; rst2 = 1'b0;

    // Basic countdown from 5, then immediate restart in the first non-busy cycle.
    load1 = 16'd5; start1 = 1'b1;
    step(); start1 = 1'b0;
    check1("cd5.e0", 16'd5, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check1("cd5.run", 16'(5 - k), 1'b1, 1'b0);
    end
    step();
    check1("cd5.term", 16'd0, 1'b0, 1'b1);
    load1 = 16'd2; start1 = 1'b1;
    step(); start1 = 1'b0;
    check1("restart.e0", 16'd2, 1'b1, 1'b0);
    step();
    check1("restart.e1", 16'd1, 1'b1, 1'b0);
    step();
    check1("restart.term", 16'd0, 1'b0, 1'b1);
    step();
    check1("restart.after", 16'd0, 1'b0, 1'b0);

    // Zero load: immediate done, never busy.
    load1 = 16'd0; start1 = 1'b1;
    step(); start1 = 1'b0;
    check1("zero.e0", 16'd0, 1'b0, 1'b1);
    step();
    check1("zero.e1", 16'd0, 1'b0, 1'b0);

    // Stop at count 3, stop+start no-op, then restart reloads 10.
    load1 = 16'd10; start1 = 1'b1;
    step(); start1 = 1'b0;
    check1("ld10.e0", 16'd10, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) step();
    check1("ld10.at3", 16'd3, 1'b1, 1'b0);
    stop1 = 1'b1;
    step();
    check1("stop.hold", 16'd3, 1'b0, 1'b0);
    start1 = 1'b1;
    step();
    check1("stopstart.noop", 16'd3, 1'b0, 1'b0);
    stop1 = 1'b0;
    step(); start1 = 1'b0;
    check1("stop.reload", 16'd10, 1'b1, 1'b0);
    stop1 = 1'b1;
    step(); stop1 = 1'b0;
    check1("stop2.hold", 16'd10, 1'b0, 1'b0);

    // Reset held 3 cycles in the middle of a run.
    load1 = 16'd5; start1 = 1'b1;
    step(); start1 = 1'b0;
    step();
    check1("pre_rst", 16'd4, 1'b1, 1'b0);
    rst1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check1("midrst", 16'd0, 1'b0, 1'b0);
    end
    rst1 = 1'b0;
    step();
    check1("post_rst", 16'd0, 1'b0, 1'b0);

`ifdef COUNTDOWN_AUTORELOAD_EN
    // Auto-reload with load 2, then clearing reload_mode ends at 0.
    rmode1 = 1'b1; load1 = 16'd2; start1 = 1'b1;
    step(); start1 = 1'b0;
    check1("rl.e0", 16'd2, 1'b1, 1'b0);
    step();
    check1("rl.e1", 16'd1, 1'b1, 1'b0);
    step();
    check1("rl.e2", 16'd2, 1'b1, 1'b1);
    step();
    check1("rl.e3", 16'd1, 1'b1, 1'b0);
    step();
    check1("rl.e4", 16'd2, 1'b1, 1'b1);
    rmode1 = 1'b0;
    step();
    check1("rl.e5", 16'd1, 1'b1, 1'b0);
    step();
    check1("rl.end", 16'd0, 1'b0, 1'b1);
    step();
    check1("rl.idle", 16'd0, 1'b0, 1'b0);
`endif

    // PRESCALE=4, load 3: busy for 12 cycles.
    load2 = 16'd3; start2 = 1'b1;
    step(); start2 = 1'b0;
    check2("p4.e0", 16'd3, 1'b1, 1'b0);
    bc = 1; got = 0;
    for (int i = 1; i <= 40 && got == 0; i++) begin
      step();
      if (busy2) bc++;
      if (done2) got = 1;
      if (i == 3) check("p4.e3.count", 32'(count2), 32'd3);
      if (i == 4) check("p4.e4.count", 32'(count2), 32'd2);
      if (i == 12) check2("p4.e12", 16'd0, 1'b0, 1'b1);
    end
    check("p4.done_seen", 32'(got), 32'd1);
    check("p4.busy_cycles", 32'(bc), 32'd12);
    step();
    check2("p4.after", 16'd0, 1'b0, 1'b0);

    // Rerun and reset at count 2.
    start2 = 1'b1;
    step(); start2 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check2("p4.at2", 16'd2, 1'b1, 1'b0);
    rst2 = 1'b1;
    step();
    check2("p4.rst", 16'd0, 1'b0, 1'b0);
    rst2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check2("p4.postrst", 16'd0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
